// File: rtl/s2p_seg_rx_pkg.sv
// Shared definitions for the segment-link serial-to-parallel receiver.
package s2p_seg_rx_pkg;

   localparam int FRAME_W_DEF     = 64;
   localparam int SYNC_STAGES_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   // Levels the link lines rest at while the link is idle
   localparam logic IDLE_S_CLK  = 1'b0;
   localparam logic IDLE_S_CLRN = 1'b1;
   localparam logic IDLE_SIN    = 1'b0;
   localparam logic IDLE_S_EN   = 1'b0;

   // Bit counter width: must be able to hold FRAME_W itself
   function automatic int cnt_w(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/s2p_seg_rx_if.sv
// Link lines in, reconstructed frame and status out.
interface s2p_seg_rx_if
   import s2p_seg_rx_pkg::*;
#(
   parameter int FRAME_W = FRAME_W_DEF
);
   localparam int CW = cnt_w(FRAME_W);

   logic               s_clk;
   logic               s_clrn;
   logic               sin;
   logic               s_en;
   logic [FRAME_W-1:0] P_Data;
   logic               valid;
   logic               frame_err;
   logic [CW-1:0]      bit_cnt;
   logic               busy;

   modport master (
      output s_clk, s_clrn, sin, s_en,
      input  P_Data, valid, frame_err, bit_cnt, busy
   );

   modport slave (
      input  s_clk, s_clrn, sin, s_en,
      output P_Data, valid, frame_err, bit_cnt, busy
   );

endinterface

// File: rtl/s2p_seg_rx_sync_edge.sv
// Multi-flop synchronizer with rising-edge detect on the synchronized output.
module sync_edge #(
   parameter int   STAGES = 2,
   parameter logic INIT   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise
);

   logic [STAGES-1:0] sync_q;
   logic              last_q;

   // Shift the raw input through the chain; keep one extra stage for edge detect
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q <= {STAGES{INIT}};
         last_q <= INIT;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
         last_q <= sync_q[STAGES-1];
      end
   end

   assign q    = sync_q[STAGES-1];
   assign rise = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/s2p_seg_rx.sv
// Segment-link receiver: oversamples the link, shifts MSB first, latches on s_en.
//
// state    | meaning
// ST_IDLE  | no bits since last clear/latch
// ST_SHIFT | receiving, fewer than FRAME_W bits so far
// ST_FULL  | FRAME_W bits held; further s_clk rises are overruns
module s2p_seg_rx
   import s2p_seg_rx_pkg::*;
#(
   parameter int FRAME_W     = FRAME_W_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic         clk,
   input  logic         rst,
   s2p_seg_rx_if.slave  bus
);

   localparam int            CW       = cnt_w(FRAME_W);
   localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_W);

   logic clk_sync, clk_rise;
   logic clrn_sync, clrn_rise_unused;
   logic sin_sync, sin_rise_unused;
   logic en_sync_unused, en_rise;

   sync_edge #(.STAGES(SYNC_STAGES), .INIT(IDLE_S_CLK)) u_sync_clk (
      .clk(clk), .rst(rst), .d(bus.s_clk), .q(clk_sync), .rise(clk_rise));
   sync_edge #(.STAGES(SYNC_STAGES), .INIT(IDLE_S_CLRN)) u_sync_clrn (
      .clk(clk), .rst(rst), .d(bus.s_clrn), .q(clrn_sync), .rise(clrn_rise_unused));
   sync_edge #(.STAGES(SYNC_STAGES), .INIT(IDLE_SIN)) u_sync_sin (
      .clk(clk), .rst(rst), .d(bus.sin), .q(sin_sync), .rise(sin_rise_unused));
   sync_edge #(.STAGES(SYNC_STAGES), .INIT(IDLE_S_EN)) u_sync_en (
      .clk(clk), .rst(rst), .d(bus.s_en), .q(en_sync_unused), .rise(en_rise));

   state_t             state_q, state_d;
   logic [FRAME_W-1:0] sr_q, sr_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [FRAME_W-1:0] p_data_q, p_data_d;
   logic               valid_q, valid_d;
   logic               err_q, err_d;
   logic               do_shift;

   // State, shift register, counter and output registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         sr_q     <= '0;
         cnt_q    <= '0;
         p_data_q <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sr_q     <= sr_d;
         cnt_q    <= cnt_d;
         p_data_q <= p_data_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end

   // Shift first, then latch from the shifted value, then apply clear
   always_comb begin
      state_d  = state_q;
      sr_d     = sr_q;
      cnt_d    = cnt_q;
      p_data_d = p_data_q;
      valid_d  = 1'b0;
      err_d    = err_q;
      do_shift = clk_rise && clrn_sync && (state_q != ST_FULL);

      if (do_shift) begin
         sr_d    = {sr_q[FRAME_W-2:0], sin_sync};
         cnt_d   = cnt_q + CW'(1);
         state_d = (cnt_d == CNT_FULL) ? ST_FULL : ST_SHIFT;
      end

      if (clk_rise && clrn_sync && (state_q == ST_FULL))
         err_d = 1'b1;

      if (en_rise) begin
         p_data_d = sr_d;
         valid_d  = 1'b1;
         if (cnt_d != CNT_FULL)
            err_d = 1'b1;
         sr_d     = '0;
         cnt_d    = '0;
         state_d  = ST_IDLE;
      end

      if (!clrn_sync) begin
         sr_d    = '0;
         cnt_d   = '0;
         state_d = ST_IDLE;
      end
   end

   assign bus.P_Data    = p_data_q;
   assign bus.valid     = valid_q;
   assign bus.frame_err = err_q;
   assign bus.bit_cnt   = cnt_q;
   assign bus.busy      = (state_q != ST_IDLE);

endmodule
